// File: rtl/instr_sequencer_if.sv
// Instruction handshake plus every datapath control line driven by instr_sequencer.
interface instr_sequencer_if;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic        illegal;
  logic [15:0] imm_out;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic        write;

  modport slave (
    input  s, in,
    output w, illegal, imm_out, readnum, writenum, vsel,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop, write
  );

  modport master (
    output s, in,
    input  w, illegal, imm_out, readnum, writenum, vsel,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop, write
  );
endinterface

// File: rtl/instr_sequencer.sv
// Moore FSM running one instruction at a time: 3 (MOV imm) to 6 (ADD/AND) cycles accept-to-ready, w=0 while busy.
// INSTR_SEQ_TRAP_EN: illegal codes lock in TRAP until reset instead of acting as a NOP.
module instr_sequencer (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);

`ifdef INSTR_SEQ_TRAP_EN
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_COMPUTE, S_WRITE_IMM, S_WRITE_REG, S_TRAP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_COMPUTE, S_WRITE_IMM, S_WRITE_REG
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movi, is_movr, is_alu, is_mvn, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_cmp  = is_alu && (op == 2'b01);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_WAIT;
      ir_q      <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_WAIT: begin
        if (bus.s) begin
          ir_d      = bus.in;
          illegal_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_movi)                state_d = S_WRITE_IMM;
        else if (is_movr || is_mvn) state_d = S_GET_B;
        else if (is_alu)            state_d = S_GET_A;
        else begin
          illegal_d = 1'b1;
`ifdef INSTR_SEQ_TRAP_EN
          state_d   = S_TRAP;
`else
          state_d   = S_WAIT;
`endif
        end
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_COMPUTE;
      S_COMPUTE:   state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_IMM: state_d = S_WAIT;
      S_WRITE_REG: state_d = S_WAIT;
`ifdef INSTR_SEQ_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_WAIT;
    endcase
  end

  always_comb begin
    bus.w        = 1'b0;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.vsel     = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.shift    = 2'b00;
    bus.ALUop    = 2'b00;
    bus.write    = 1'b0;
    case (state_q)
      S_WAIT:  bus.w = 1'b1;
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      S_COMPUTE: begin
        bus.shift = sh;
        bus.ALUop = is_alu ? op : 2'b00;
        // MOV reg and MVN zero the A side so the ALU passes (or inverts) B alone
        bus.asel  = is_movr || is_mvn;
        if (is_cmp) bus.loads = 1'b1;
        else        bus.loadc = 1'b1;
      end
      S_WRITE_IMM: begin
        bus.writenum = rn;
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
      end
      S_WRITE_REG: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;
  assign bus.imm_out = {{8{ir_q[7]}}, ir_q[7:0]};
  assign bus.bsel    = 1'b0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed-vector bench for instr_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_sequencer_if bus();

  instr_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [31:0] ctl();
    return {14'd0, bus.readnum, bus.writenum, bus.vsel, bus.loada, bus.loadb, bus.loadc,
            bus.loads, bus.asel, bus.bsel, bus.shift, bus.ALUop, bus.write};
  endfunction

  // Issue one instruction and follow it back to WAIT, recording what the controls did.
  task automatic run_instr(input logic [15:0] instr, output int lat, output logic saw_write,
                           output logic [2:0] wnum, output logic saw_loadc, output logic saw_loads,
                           output logic [4:0] snap, output logic excl_bad);
    saw_write = 1'b0; wnum = 3'd0; saw_loadc = 1'b0; saw_loads = 1'b0;
    snap = 5'd0; excl_bad = 1'b0;
    bus.in = instr;
    bus.s  = 1'b1;
    tick();
    bus.s = 1'b0;
    lat = 1;
    for (int k = 0; k < 40; k++) begin
      if (bus.write) begin
        saw_write = 1'b1;
        wnum = bus.writenum;
      end
      if (bus.loadc || bus.loads) snap = {bus.asel, bus.ALUop, bus.shift};
      saw_loadc = saw_loadc | bus.loadc;
      saw_loads = saw_loads | bus.loads;
      if ($countones({bus.write, bus.loadc, bus.loads}) > 1) excl_bad = 1'b1;
      if (bus.w) break;
      tick();
      lat++;
    end
  endtask

  int         lat;
  logic       sw, slc, sls, xb;
  logic [2:0] wn;
  logic [4:0] sn;
  int         bad;

  initial begin
    bus.s  = 1'b0;
    bus.in = 16'h0000;
    reset  = 1'b1;
    tick();
    chk_vec("rst_w", bus.w, 1);
    chk_vec("rst_illegal", bus.illegal, 0);
    chk_vec("rst_imm", bus.imm_out, 16'h0000);
    chk_vec("rst_ctl", ctl(), 0);
    reset = 1'b0;
    tick();

    // MOV R1,#7 step by step
    bus.in = 16'hD107; bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
    chk_vec("movi_dec_w", bus.w, 0);
    tick();
    chk_vec("movi_w_busy", bus.w, 0);
    chk_vec("movi_writenum", bus.writenum, 1);
    chk_vec("movi_vsel", bus.vsel, 1);
    chk_vec("movi_write", bus.write, 1);
    chk_vec("movi_imm", bus.imm_out, 16'h0007);
    tick();
    chk_vec("movi_done_w", bus.w, 1);

    // MOV R2,#-5
    run_instr(16'hD2FB, lat, sw, wn, slc, sls, sn, xb);
    chk_vec("movneg_lat", lat, 3);
    chk_vec("movneg_imm", bus.imm_out, 16'hFFFB);
    chk_vec("movneg_wnum", wn, 2);

    // ADD R5,R0,R1,LSL#1 step by step
    bus.in = 16'hA0A9; bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
    chk_vec("add_dec_ctl", ctl(), 0);
    tick();
    chk_vec("add_geta_rn", bus.readnum, 0);
    chk_vec("add_geta_loada", bus.loada, 1);
    tick();
    chk_vec("add_getb_rm", bus.readnum, 1);
    chk_vec("add_getb_loadb", bus.loadb, 1);
    chk_vec("add_getb_loada", bus.loada, 0);
    tick();
    chk_vec("add_cmp_shift", bus.shift, 2'b01);
    chk_vec("add_cmp_aluop", bus.ALUop, 2'b00);
    chk_vec("add_cmp_loadc", bus.loadc, 1);
    chk_vec("add_cmp_asel", bus.asel, 0);
    tick();
    chk_vec("add_wr_wnum", bus.writenum, 5);
    chk_vec("add_wr_write", bus.write, 1);
    chk_vec("add_wr_vsel", bus.vsel, 0);
    chk_vec("add_wr_w", bus.w, 0);
    tick();
    chk_vec("add_done_w", bus.w, 1);

    // CMP R1,R0 step by step
    bus.in = 16'hA900; bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
    sw = bus.write;
    tick();
    sw |= bus.write;
    chk_vec("cmp_geta_rn", bus.readnum, 1);
    tick();
    sw |= bus.write;
    chk_vec("cmp_getb_rm", bus.readnum, 0);
    tick();
    sw |= bus.write;
    chk_vec("cmp_aluop", bus.ALUop, 2'b01);
    chk_vec("cmp_loads", bus.loads, 1);
    chk_vec("cmp_loadc", bus.loadc, 0);
    tick();
    sw |= bus.write;
    chk_vec("cmp_done_w", bus.w, 1);
    chk_vec("cmp_no_write", sw, 0);

    // MVN R3,R2,LSR
    run_instr(16'hB872, lat, sw, wn, slc, sls, sn, xb);
    chk_vec("mvn_lat", lat, 5);
    chk_vec("mvn_wnum", wn, 3);
    chk_vec("mvn_compute", sn, 5'b1_11_10);
    chk_vec("mvn_excl", xb, 0);

    // MOV R4,R6
    run_instr(16'hC086, lat, sw, wn, slc, sls, sn, xb);
    chk_vec("movr_lat", lat, 5);
    chk_vec("movr_wnum", wn, 4);
    chk_vec("movr_compute", sn, 5'b1_00_00);
    chk_vec("movr_loads", sls, 0);

    // AND R7,R2,R3
    run_instr(16'hB2E3, lat, sw, wn, slc, sls, sn, xb);
    chk_vec("and_lat", lat, 6);
    chk_vec("and_wnum", wn, 7);
    chk_vec("and_compute", sn, 5'b0_10_00);
    chk_vec("and_excl", xb, 0);

    // Reset during GET_B of an ADD
    bus.in = 16'hA0A9; bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
    tick();
    tick();
    chk_vec("midrst_getb", bus.loadb, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_vec("midrst_w", bus.w, 1);
    chk_vec("midrst_write", bus.write, 0);
    chk_vec("midrst_imm", bus.imm_out, 16'h0000);
    tick();
    chk_vec("midrst_after_write", bus.write, 0);

    // s held high across two MOV imm instructions
    bus.in = 16'hD107; bus.s = 1'b1;
    tick();
    bus.in = 16'hD305;
    chk_vec("b2b_dec1_w", bus.w, 0);
    tick();
    chk_vec("b2b_imm1", bus.imm_out, 16'h0007);
    chk_vec("b2b_wnum1", bus.writenum, 1);
    tick();
    chk_vec("b2b_wait_w", bus.w, 1);
    tick();
    chk_vec("b2b_dec2_w", bus.w, 0);
    bus.s = 1'b0;
    tick();
    chk_vec("b2b_imm2", bus.imm_out, 16'h0005);
    chk_vec("b2b_wnum2", bus.writenum, 3);
    tick();
    chk_vec("b2b_done_w", bus.w, 1);

`ifdef INSTR_SEQ_TRAP_EN
    bus.in = 16'h0000; bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
    chk_vec("trap_dec_w", bus.w, 0);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      bus.s  = (i % 3 == 0);
      bus.in = 16'hD107;
      if (bus.w !== 1'b0 || bus.illegal !== 1'b1 || ctl() !== 32'd0) bad++;
    end
    bus.s = 1'b0;
    chk_vec("trap_hold", bad, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_vec("trap_rst_w", bus.w, 1);
    chk_vec("trap_rst_illegal", bus.illegal, 0);
`else
    run_instr(16'h0000, lat, sw, wn, slc, sls, sn, xb);
    chk_vec("ill0_lat", lat, 2);
    chk_vec("ill0_flag", bus.illegal, 1);
    chk_vec("ill0_write", sw, 0);
    run_instr(16'hC800, lat, sw, wn, slc, sls, sn, xb);
    chk_vec("ill1_lat", lat, 2);
    chk_vec("ill1_flag", bus.illegal, 1);
    bus.in = 16'hD107; bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
    chk_vec("ill_clear", bus.illegal, 0);
    tick();
    tick();
    chk_vec("ill_next_w", bus.w, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Moore-FSM controller that sequences the 16-bit register-file/shifter/ALU datapath through single-instruction execution. It accepts one 16-bit instruction under a start/wait handshake, decodes it, and drives every datapath control port: register read/write numbers, operand loads, mux selects, shift, ALUop and status load. It sits between the instruction source (switches or a fetch unit) and the datapath, with one instruction in flight at a time.

## Interface
- No parameters; all widths are fixed by the datapath.
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high; returns FSM to WAIT
- s  in  1  start request; sampled only in WAIT
- in  in  16  instruction word; captured into IR when s && w
- w  out  1  high only in WAIT (ready for instruction)
- illegal  out  1  decoded opcode/op is unsupported
- imm_out  out  16  sign-extended IR[7:0], drives datapath_in
- readnum, writenum  out  3  register-file read/write select
- vsel  out  1  1 = write imm_out, 0 = write datapath_out
- loada, loadb, loadc, loads  out  1  datapath register loads
- asel  out  1  1 = A operand forced to zero
- bsel  out  1  held 0 (shifter path); the immediate-B path is not used
- shift  out  2  shifter control
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- write  out  1  register-file write enable

## Operation
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Supported instructions:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD Rd,Rn,Rm{,sh}
  - 101/01: CMP Rn,Rm{,sh}
  - 101/10: AND Rd,Rn,Rm{,sh}
  - 101/11: MVN Rd,Rm{,sh}
  - All other codes are illegal.
- States: WAIT, DECODE, GET_A, GET_B, COMPUTE, WRITE_IMM, WRITE_REG (plus TRAP, see Configuration).
- Outputs in each state; any signal not listed is 0:
  - WAIT: w=1. If s=1, capture IR and go to DECODE.
  - DECODE: MOV imm goes to WRITE_IMM. MOV reg and MVN go to GET_B. ADD, CMP and AND go to GET_A. Illegal codes set illegal=1 and return to WAIT.
  - GET_A: readnum=Rn, loada=1, then GET_B.
  - GET_B: readnum=Rm, loadb=1, then COMPUTE.
  - COMPUTE: shift=sh. ALUop=op for opcode 101, 00 for MOV reg. asel=1 for MOV reg and MVN. CMP asserts loads=1 (no loadc) and goes to WAIT; all others assert loadc=1 and go to WRITE_REG.
  - WRITE_IMM: writenum=Rn, vsel=1, write=1, then WAIT.
  - WRITE_REG: writenum=Rd, vsel=0, write=1, then WAIT.
- imm_out = {{8{IR[7]}}, IR[7:0]} combinationally from IR at all times.
- IR holds its value until the next accept; `in` is ignored outside WAIT.
- illegal is registered. It is set in DECODE and cleared on the next accept or on reset.

## Timing
- Reset (synchronous): state=WAIT, IR=0, illegal=0.
  - Outputs after reset: w=1; every other output 0, including imm_out=0.
  - Reset asserted in any state, including mid-instruction, takes effect at the next posedge. Any pending write is abandoned, with no write asserted after that edge.
- Latency, counted in cycles from the accept edge to w=1:
  - MOV imm: 3
  - MOV reg, MVN, CMP: 5
  - ADD, AND: 6
  - illegal: 2
- s is level-sampled. If s is still high when WAIT is re-entered, the next instruction is accepted on that first WAIT cycle (back-to-back, no idle cycle).
- s pulses outside WAIT are ignored, not queued.
- Register file reads are combinational, so readnum is valid in the same cycle its load is asserted.
- Writes take effect at the posedge ending WRITE_IMM/WRITE_REG.
- At most one of write, loadc, loads is asserted in any cycle.

## Configuration
- Macro: INSTR_SEQ_TRAP_EN.
- Defined: an illegal code in DECODE goes to TRAP. TRAP holds illegal=1, w=0 and all controls 0 until reset. s is ignored.
- Undefined: no TRAP state. An illegal code returns to WAIT after DECODE, with illegal=1 until the next accept (NOP behaviour).

## Test plan
- Reset then MOV imm: reset 1 cycle; in=16'hD107 (MOV R1,#7) with s=1 for 1 cycle.
  - Required: w low for 2 cycles.
  - In WRITE_IMM: writenum=1, vsel=1, write=1, imm_out=16'h0007.
  - w=1 on the 3rd cycle.
- Negative immediate: in=16'hD2FB (MOV R2,#-5) -> imm_out=16'hFFFB.
- ADD sequence: in=16'hA0A9 (ADD R5,R0,R1,LSL#1). Required controls per state:
  - GET_A: readnum=0, loada=1.
  - GET_B: readnum=1, loadb=1.
  - COMPUTE: shift=01, ALUop=00, loadc=1.
  - WRITE_REG: writenum=5, write=1.
  - w returns after 6 cycles.
- CMP, no writeback: in=16'hA900 (CMP R1,R0).
  - COMPUTE has ALUop=01, loads=1, loadc=0.
  - write never asserts.
  - w=1 after 5 cycles.
- Reset mid-instruction and back-to-back: assert reset during GET_B of an ADD -> next cycle w=1, write=0, IR=0.
  - Then hold s=1 across two MOV imm instructions -> second is accepted on the first WAIT cycle.
- Illegal code: in=16'h0000.
  - Without INSTR_SEQ_TRAP_EN: illegal=1 and w=1 two cycles after accept.
  - With INSTR_SEQ_TRAP_EN: w stays 0 and illegal stays 1 for 20+ cycles, until reset clears both.
